imem_fetch_responder: RTL and testbench

Responder end of the program-counter address interface: accepts the 10-bit byte address from the PC and returns the 32-bit instruction stored at that address.
- Owns the 1024-byte instruction store.
- Provides a byte-serial program-load port, sequenced by a small state machine.
- Registered read (1-cycle latency), kill/flush support, and error flags for the fetch stage feeding decode.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_byte_ram.sv | 41 ++++
 rtl/imem_fetch_responder.sv | 146 ++++++++++++++
 tb/tb_imem_fetch_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared constants and types for the instruction-memory fetch responder.
//   MEM_BYTES : instruction store size in bytes (power of two)
//   ADDR_W    : byte address width, log2(MEM_BYTES)
//   NOP_INSTR : instruction presented whenever the output is not a real fetch
//   state_e   : responder mode (IDLE -> LOAD -> RUN)
// ---------------------------------------------------------------------------
package imem_pkg;

   localparam int          MEM_BYTES = 1024;
   localparam int          ADDR_W    = 10;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/imem_byte_ram.sv
// ---------------------------------------------------------------------------
// imem_byte_ram
// Single-port byte RAM: synchronous byte write, asynchronous 4-lane word read.
// The read port takes a word index, so the four lanes are always the bytes
// of one aligned word and can never run past the end of the store.
// Ports:
//   clk      : clock
//   we_i     : write enable for this cycle
//   waddr_i  : byte write address
//   wdata_i  : byte to write
//   rword_i  : word index to read (byte address >> 2)
//   rdata_o  : little-endian word {mem[a+3],mem[a+2],mem[a+1],mem[a]}
// ---------------------------------------------------------------------------
module imem_byte_ram #(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic [ADDR_W-3:0] rword_i,
   output logic [31:0]       rdata_o
);

   // Contents are deliberately not reset: a reset mid-program-load keeps
   // old bytes until the next load overwrites them.
   logic [7:0] mem [MEM_BYTES];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = {mem[{rword_i, 2'd3}],
                     mem[{rword_i, 2'd2}],
                     mem[{rword_i, 2'd1}],
                     mem[{rword_i, 2'd0}]};

endmodule

// File: rtl/imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// imem_fetch_responder
// Responder end of the PC address interface. Owns the instruction store,
// accepts a byte-serial program load, then serves registered (1-cycle)
// word fetches with kill/flush and sticky error flags.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   load_en        : load_byte valid this cycle
//   load_byte      : program byte, written at the internal load pointer
//   load_done      : pulse, loading finished -> RUN
//   pc_addr        : fetch byte address
//   kill           : squash the instruction registered at this edge
//   instr_out      : fetched instruction (NOP_INSTR when not valid)
//   instr_valid    : instr_out is a real fetched instruction
//   load_count     : bytes accepted so far (0..MEM_BYTES)
//   load_overflow  : sticky, a load byte arrived with the store full
//   misalign_err   : sticky, an unkilled RUN fetch had pc_addr[1:0] != 0
// ---------------------------------------------------------------------------
module imem_fetch_responder #(
   parameter int          MEM_BYTES = imem_pkg::MEM_BYTES,
   parameter int          ADDR_W    = imem_pkg::ADDR_W,
   parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic [7:0]        load_byte,
   input  logic              load_done,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic              kill,
   output logic [31:0]       instr_out,
   output logic              instr_valid,
   output logic [ADDR_W:0]   load_count,
   output logic              load_overflow,
   output logic              misalign_err
);

   import imem_pkg::*;

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(MEM_BYTES);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              misalign_q, misalign_d;
   logic [31:0]       instr_q, instr_d;
   logic              valid_q, valid_d;

   logic              loading;
   logic              full;
   logic              ram_we;
   logic              misaligned;
   logic [31:0]       ram_rdata;

   assign loading    = (state_q != RUN);
   assign full       = (count_q == FULL_COUNT);
   // The byte count doubles as the load pointer; once full it stops moving
   // so an overflowing byte can never wrap onto address 0.
   assign ram_we     = loading && load_en && !full;
   assign misaligned = |pc_addr[1:0];

   imem_byte_ram #(
      .MEM_BYTES (MEM_BYTES),
      .ADDR_W    (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (count_q[ADDR_W-1:0]),
      .wdata_i (load_byte),
      .rword_i (pc_addr[ADDR_W-1:2]),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      misalign_d = misalign_q;
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // A byte together with load_done is written and then RUN.
            if (load_en) begin
               state_d = load_done ? RUN : LOAD;
            end else if (load_done) begin
               state_d = RUN;
            end
         end
         LOAD: begin
            if (load_done) begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (ram_we) begin
         count_d = count_q + 1'b1;
      end
      if (loading && load_en && full) begin
         overflow_d = 1'b1;
      end

      // kill outranks the alignment check, so a squashed fetch never flags.
      if (state_q == RUN && !kill) begin
         if (misaligned) begin
            misalign_d = 1'b1;
         end else begin
            instr_d = ram_rdata;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         overflow_q <= 1'b0;
         misalign_q <= 1'b0;
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         misalign_q <= misalign_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_out     = instr_q;
   assign instr_valid   = valid_q;
   assign load_count    = count_q;
   assign load_overflow = overflow_q;
   assign misalign_err  = misalign_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_responder
// Self-checking bench: directed scenarios plus randomized load/fetch rounds,
// all compared against a byte-array reference model of the responder.
// ---------------------------------------------------------------------------
module tb_imem_fetch_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic [7:0]  load_byte;
   logic        load_done;
   logic [9:0]  pc_addr;
   logic        kill;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic [10:0] load_count;
   logic        load_overflow;
   logic        misalign_err;

   imem_fetch_responder dut (
      .clk           (clk),
      .reset         (reset),
      .load_en       (load_en),
      .load_byte     (load_byte),
      .load_done     (load_done),
      .pc_addr       (pc_addr),
      .kill          (kill),
      .instr_out     (instr_out),
      .instr_valid   (instr_valid),
      .load_count    (load_count),
      .load_overflow (load_overflow),
      .misalign_err  (misalign_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Reference model: the store as a byte array, a byte counter and a
   // "running" flag (loading vs running is all the behaviour depends on).
   logic [7:0]  mem_m [1024];
   int          cnt_m;
   bit          run_m, ovf_m, mis_m, vld_m;
   logic [31:0] instr_m;
   logic [7:0]  stream [1025];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passed++;
      else $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_edge();
      int a;
      if (reset) begin
         run_m = 0; cnt_m = 0; ovf_m = 0; mis_m = 0; vld_m = 0; instr_m = NOP;
      end else begin
         instr_m = NOP;
         vld_m   = 0;
         if (run_m) begin
            if (!kill) begin
               if (pc_addr % 4 != 0) mis_m = 1;
               else begin
                  a = int'(pc_addr);
                  instr_m = {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
                  vld_m = 1;
               end
            end
         end else begin
            if (load_en) begin
               if (cnt_m == 1024) ovf_m = 1;
               else begin
                  mem_m[cnt_m] = load_byte;
                  cnt_m++;
               end
            end
            if (load_done) run_m = 1;
         end
      end
   endtask

   task automatic step(input bit r, input bit le, input logic [7:0] lb,
                       input bit ld, input logic [9:0] pc, input bit k);
      reset = r; load_en = le; load_byte = lb; load_done = ld; pc_addr = pc; kill = k;
      @(posedge clk);
      model_edge();
      #1;
      check("instr_out",     instr_out,            instr_m);
      check("instr_valid",   32'(instr_valid),     32'(vld_m));
      check("load_count",    32'(load_count),      32'(cnt_m));
      check("load_overflow", 32'(load_overflow),   32'(ovf_m));
      check("misalign_err",  32'(misalign_err),    32'(mis_m));
   endtask

   task automatic do_reset();
      step(1, 0, 8'h00, 0, 10'd0, 0);
   endtask

   logic [7:0] prog8 [8];
   logic [7:0] reload4 [4];

   initial begin
      prog8   = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      reload4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      reset = 1; load_en = 0; load_byte = 0; load_done = 0; pc_addr = 0; kill = 0;

      // Reset state and fetch while in IDLE.
      do_reset();
      check("rst_instr", instr_out, NOP);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_count", 32'(load_count), 32'd0);
      step(0, 0, 8'h00, 0, 10'd0, 0);
      check("idle_fetch_valid", 32'(instr_valid), 32'd0);
      check("idle_fetch_instr", instr_out, NOP);

      // Overflow: 1025 bytes fill the whole store (making all of it known).
      for (int i = 0; i < 1025; i++) begin
         stream[i] = 8'($urandom);
         step(0, 1, stream[i], 0, 10'd0, 0);
      end
      check("ovf_count", 32'(load_count), 32'd1024);
      check("ovf_flag",  32'(load_overflow), 32'd1);
      step(0, 0, 8'h00, 1, 10'd0, 0);
      step(0, 0, 8'h00, 0, 10'd1020, 0);
      check("ovf_last_word", instr_out,
            {stream[1023], stream[1022], stream[1021], stream[1020]});
      step(0, 0, 8'h00, 0, 10'd0, 0);
      check("ovf_first_byte", 32'(instr_out[7:0]), 32'(stream[0]));

      // Small program load, then aligned fetches.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(0, 1, prog8[i], 0, 10'd0, 0);
         check("load_fetch_valid", 32'(instr_valid), 32'd0);
      end
      step(0, 0, 8'h00, 1, 10'd0, 0);
      step(0, 0, 8'h00, 0, 10'd0, 0);
      check("word0", instr_out, 32'h0000_0013);
      check("word0_valid", 32'(instr_valid), 32'd1);
      step(0, 0, 8'h00, 0, 10'd4, 0);
      check("word4", instr_out, 32'h0010_0093);
      check("prog_count", 32'(load_count), 32'd8);

      // Kill, kill over misalign, then sticky misalign.
      step(0, 0, 8'h00, 0, 10'd4, 1);
      check("kill_valid", 32'(instr_valid), 32'd0);
      check("kill_instr", instr_out, NOP);
      step(0, 0, 8'h00, 0, 10'd8, 0);
      check("after_kill_valid", 32'(instr_valid), 32'd1);
      check("after_kill_word", instr_out, {stream[11], stream[10], stream[9], stream[8]});
      step(0, 0, 8'h00, 0, 10'd5, 1);
      check("kill_mis_clear", 32'(misalign_err), 32'd0);
      step(0, 0, 8'h00, 0, 10'd6, 0);
      check("mis_set", 32'(misalign_err), 32'd1);
      check("mis_valid", 32'(instr_valid), 32'd0);
      step(0, 1, 8'h55, 1, 10'd0, 0);  // load inputs ignored in RUN
      check("mis_sticky", 32'(misalign_err), 32'd1);
      check("run_ignores_load", 32'(load_count), 32'd8);

      // Reset mid-load, reload with the last byte paired with load_done.
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 0, 10'd0, 0);
      do_reset();
      check("midload_count", 32'(load_count), 32'd0);
      for (int i = 0; i < 4; i++) step(0, 1, reload4[i], (i == 3), 10'd0, 0);
      check("reload_count", 32'(load_count), 32'd4);
      step(0, 0, 8'h00, 0, 10'd0, 0);
      check("reload_word", instr_out, 32'hDDCC_BBAA);
      check("reload_valid", 32'(instr_valid), 32'd1);

      // Randomized rounds: variable-length loads with gaps, then fetches.
      for (int r = 0; r < 6; r++) begin
         int n;
         do_reset();
         n = $urandom_range(0, 40);
         for (int i = 0; i < n; ) begin
            bit le;
            le = ($urandom_range(0, 3) != 0);
            step(0, le, 8'($urandom), (le && i == n - 1 && r[0]),
                 10'($urandom), 1'($urandom));
            if (le) i++;
         end
         if (!(r[0] && n > 0)) step(0, 0, 8'h00, 1, 10'd0, 0);
         for (int i = 0; i < 150; i++) begin
            logic [9:0] pc;
            pc = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            step(0, ($urandom_range(0, 9) == 0), 8'($urandom),
                 ($urandom_range(0, 9) == 0), pc, ($urandom_range(0, 7) == 0));
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
